// File: rtl/addsub_issue_queue.sv
// addsub_issue_queue: request FIFO feeding an external 16-bit adder-subtractor, one-entry response register.
// Latency: a request accepted at edge N into an empty queue shows rsp_valid after edge N+1; 1 result/cycle sustained.
// Backpressure: req_ready = !fifo_full (no bypass); the response register holds while rsp_valid && !rsp_ready.
// Optional feature macro: ADDSUB_STICKY_FLAGS_EN adds clr_sticky / sticky_over / sticky_carry.

// Generic synchronous FIFO with a combinational head output.
module addsub_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_vld,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop_vld,
  output logic [WIDTH-1:0] head_dat,
  output logic             empty,
  output logic             full
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign do_push  = push_vld && !full;
  assign do_pop   = pop_vld && !empty;
  assign head_dat = mem[rd_ptr];

  // Storage write; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  // Pointers wrap naturally since DEPTH is a power of two; count holds on push+pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (do_pop && !do_push) count <= count - CW'(1);
    end
  end
endmodule

module addsub_issue_queue #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  input  logic        req_sub,
  output logic [15:0] op1,
  output logic [15:0] op2,
  output logic        Op,
  input  logic [15:0] Out,
  input  logic        over,
  input  logic        carry,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic        rsp_over,
  output logic        rsp_carry,
  output logic [7:0]  rsp_tag
`ifdef ADDSUB_STICKY_FLAGS_EN
  ,
  input  logic        clr_sticky,
  output logic        sticky_over,
  output logic        sticky_carry
`endif
);
  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
  } req_t;

  typedef enum logic {ST_EMPTY, ST_HOLD} state_t;

  state_t state;
  state_t state_nxt;
  req_t   push_req;
  req_t   head_req;
  logic   fifo_empty;
  logic   fifo_full;
  logic   issue;
  logic [7:0] issue_cnt;

  assign push_req  = '{a: req_a, b: req_b, sub: req_sub};
  assign req_ready = !fifo_full;
  assign issue     = !fifo_empty && (!rsp_valid || rsp_ready);

  addsub_fifo #(.WIDTH($bits(req_t)), .DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push_vld (req_valid),
    .push_dat (push_req),
    .pop_vld  (issue),
    .head_dat (head_req),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  // Head operands go straight to the arithmetic unit; forced to zero when nothing is queued.
  assign op1 = fifo_empty ? 16'h0000 : head_req.a;
  assign op2 = fifo_empty ? 16'h0000 : head_req.b;
  assign Op  = fifo_empty ? 1'b0     : head_req.sub;

  // Output-side state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_EMPTY;
    else        state <= state_nxt;
  end

  // Next state: fill on issue, empty only on a drain without a replacement issue.
  always_comb begin
    state_nxt = state;
    rsp_valid = (state == ST_HOLD);
    case (state)
      ST_EMPTY: if (issue) state_nxt = ST_HOLD;
      ST_HOLD:  if (rsp_ready && !issue) state_nxt = ST_EMPTY;
      default:  state_nxt = ST_EMPTY;
    endcase
  end

  // Capture the adder result and tag on every issue; otherwise hold stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_data  <= 16'h0000;
      rsp_over  <= 1'b0;
      rsp_carry <= 1'b0;
      rsp_tag   <= 8'h00;
      issue_cnt <= 8'h00;
    end else if (issue) begin
      rsp_data  <= Out;
      rsp_over  <= over;
      rsp_carry <= carry;
      rsp_tag   <= issue_cnt;
      issue_cnt <= issue_cnt + 8'h01;
    end
  end

`ifdef ADDSUB_STICKY_FLAGS_EN
  // Sticky flags accumulate issued over/carry; a same-cycle set beats the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_over  <= 1'b0;
      sticky_carry <= 1'b0;
    end else begin
      if (issue && over)   sticky_over  <= 1'b1;
      else if (clr_sticky) sticky_over  <= 1'b0;
      if (issue && carry)  sticky_carry <= 1'b1;
      else if (clr_sticky) sticky_carry <= 1'b0;
    end
  end
`endif
endmodule

// File: doc/addsub_issue_queue.md
ADDSUB_ISSUE_QUEUE -- requirements
Module: addsub_issue_queue

Interface
REQ-001 Parameter DEPTH, default 4, request FIFO entries; power of two, 2..16.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 req_valid  input  1  upstream request present.
REQ-005 req_ready  output  1  queue can accept a request this cycle.
REQ-006 req_a, req_b  input  16 each  operands.
REQ-007 req_sub  input  1  1 = subtract (a-b), 0 = add (a+b).
REQ-008 op1, op2  output  16 each  operands driven to the external 16-bit adder-subtractor.
REQ-009 Op  output  1  operation select driven to the adder-subtractor.
REQ-010 Out  input  16  adder-subtractor result (combinational from op1/op2/Op).
REQ-011 over, carry  input  1 each  adder-subtractor overflow and carry/borrow flags.
REQ-012 rsp_valid  output  1  response register holds a result.
REQ-013 rsp_ready  input  1  downstream accepts response.
REQ-014 rsp_data  output  16  captured result.
REQ-015 rsp_over, rsp_carry  output  1 each  captured flags.
REQ-016 rsp_tag  output  8  issue sequence number of the captured result.

Function
REQ-017 Push on req_valid && req_ready; req_ready = !fifo_full; no push bypass when full, even if a pop occurs the same cycle.
REQ-018 op1/op2/Op SHALL be driven combinationally from the FIFO head; all zero when FIFO empty.
REQ-019 Issue (pop) when FIFO non-empty and (rsp_valid == 0 or rsp_ready == 1); on that edge Out/over/carry are captured into rsp_data/rsp_over/rsp_carry, rsp_tag <= issue counter, rsp_valid <= 1.
REQ-020 rsp_valid clears on rsp_valid && rsp_ready with no issue that cycle; issue and drain in the same cycle keep rsp_valid = 1 with new data.
REQ-021 Response register contents SHALL stay stable while rsp_valid && !rsp_ready.
REQ-022 Latency: request accepted at edge N into empty queue -> rsp_valid high after edge N+1; sustained throughput one result per cycle with rsp_ready held 1.
REQ-023 Output-side state machine: EMPTY (rsp_valid=0), HOLD (rsp_valid=1, waiting), with EMPTY->HOLD on issue, HOLD->EMPTY on drain without issue, HOLD->HOLD on drain with issue or stall.
REQ-024 Issue counter 8 bits, +1 per issue, wraps 0xFF -> 0x00; first result after reset tags 0x00.
REQ-025 FIFO pointers wrap modulo DEPTH; count tracks 0..DEPTH; simultaneous push and pop leaves count unchanged.
REQ-026 Maximum in flight: DEPTH in FIFO plus one in response register.

Reset
REQ-027 On rst_n low, immediately: FIFO empty, count 0, issue counter 0, rsp_valid 0, rsp_data 0x0000, rsp_over 0, rsp_carry 0, rsp_tag 0x00, req_ready 1 (after release), state EMPTY.
REQ-028 Reset mid-operation discards all queued and held results; no response emitted for them.

Configuration
REQ-029 Macro ADDSUB_STICKY_FLAGS_EN: when defined, adds input clr_sticky (1) and outputs sticky_over, sticky_carry (1 each), set by any issued result with over/carry = 1, cleared by clr_sticky, reset to 0; set wins over clear in the same cycle.
REQ-030 Without ADDSUB_STICKY_FLAGS_EN the three ports and their logic SHALL be absent; all other behaviour identical.

Verification
REQ-031 Add 0x7FFF + 0x0001, rsp_ready=1 -> rsp_data 0x8000, rsp_over 1, rsp_carry 0, rsp_tag 0x00, rsp_valid one cycle after accept edge.
REQ-032 Sub 0x0000 - 0x0001 -> rsp_data 0xFFFF, rsp_carry 1, rsp_over 0.
REQ-033 rsp_ready=0, push continuously -> exactly DEPTH+1 (5) accepted, req_ready low thereafter; release rsp_ready -> 5 results in order, tags 0..4, one per cycle.
REQ-034 300 back-to-back adds with rsp_ready=1 -> no bubbles, rsp_tag wraps 0xFF -> 0x00 at result 257.
REQ-035 Assert rst_n low with 3 queued and one held -> rsp_valid 0 immediately, no stale results after release, next tag 0x00.
REQ-036 With ADDSUB_STICKY_FLAGS_EN: overflow result then non-overflow results -> sticky_over stays 1 until clr_sticky; clr_sticky coincident with overflow issue -> sticky_over remains 1.
